// File: rtl/line_window_scheduler_if.sv
// Stream, FIFO-control and window-marker bundle of the line window scheduler.
// The slave view belongs to the scheduler; master is its pixel source/consumer.
interface line_window_scheduler_if #(
    parameter int LINES_NUM = 3
);
    logic                     s_pixel_valid;
    logic                     s_ready;
    logic                     fifo_srst;
    logic [LINES_NUM-2:0]     fifo_wr_en;
    logic [LINES_NUM-2:0]     fifo_rd_en;
    logic [3*LINES_NUM-1:0]   row_sel;
    logic                     m_pixel_valid;
    logic                     m_sof;
    logic                     m_eol;
    logic                     m_eof;
    logic [1:0]               state;

    modport slave (
        input  s_pixel_valid,
        output s_ready, fifo_srst, fifo_wr_en, fifo_rd_en, row_sel,
        output m_pixel_valid, m_sof, m_eol, m_eof, state
    );

    modport master (
        output s_pixel_valid,
        input  s_ready, fifo_srst, fifo_wr_en, fifo_rd_en, row_sel,
        input  m_pixel_valid, m_sof, m_eol, m_eof, state
    );
endinterface

// File: rtl/line_window_scheduler.sv
// Sequencer for a cascade of line FIFOs feeding a vertical filter window:
// FIFO enables, tail drain at frame end, edge-replicating tap selects, markers.
module line_window_scheduler #(
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int LINES_NUM    = 3
) (
    input logic clk,
    input logic rst,
    line_window_scheduler_if.slave bus
);
    localparam int K  = (LINES_NUM - 1) / 2;
    localparam int NF = LINES_NUM - 1;
    localparam logic [10:0] HOR_LAST    = 11'(IMAGE_WIDTH - 1);
    localparam logic [11:0] V_PRE_LAST  = 12'(K - 1);
    localparam logic [11:0] V_IN_LAST   = 12'(IMAGE_HEIGHT - 1);
    localparam logic [11:0] V_FL_LAST   = 12'(IMAGE_HEIGHT + LINES_NUM - 2);
    localparam logic [11:0] V_OUT_FIRST = 12'(K);
    localparam logic [11:0] V_OUT_LAST  = 12'(IMAGE_HEIGHT - 1 + K);

    typedef enum logic [1:0] {
        PREFILL = 2'd0,
        STREAM  = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [10:0] hor;
    logic [11:0] v;
    logic [1:0] srst_cnt;
    logic srst;
    logic ready;
    logic accept;
    logic beat;
    logic line_end;
    logic win_valid;
    logic [NF-1:0] rd_en;
    logic [NF-2:0] wr_dly;
    logic [3*LINES_NUM-1:0] sel;
    int vi;
    int r;

    logic mv_q, sof_q, eol_q, eof_q;
    logic [3*LINES_NUM-1:0] row_sel_q;

    assign ready    = !rst && !srst && (state_q != FLUSH);
    assign accept   = bus.s_pixel_valid && ready;
    // Drain rows run on their own at one beat per cycle; input is held off.
    assign beat     = (state_q == FLUSH) ? !rst : accept;
    assign line_end = beat && (hor == HOR_LAST);

    always_comb begin
        state_d   = state_q;
        rd_en     = '0;
        sel       = '0;
        vi        = int'(v);
        r         = 0;
        win_valid = beat && (v >= V_OUT_FIRST) && (v <= V_OUT_LAST);

        unique case (state_q)
            PREFILL: if (line_end && v == V_PRE_LAST) state_d = STREAM;
            STREAM:  if (line_end && v == V_IN_LAST)  state_d = FLUSH;
            FLUSH:   if (line_end && v == V_FL_LAST)  state_d = PREFILL;
            default: state_d = PREFILL;
        endcase

        // FIFO i holds row v-i-1; while draining, FIFO i is emptied by row H+i.
        for (int i = 0; i < NF; i++) begin
            if (state_q == FLUSH)
                rd_en[i] = beat && (i + IMAGE_HEIGHT >= vi);
            else
                rd_en[i] = beat && (vi > i);
        end

        for (int j = 0; j < LINES_NUM; j++) begin
            r = vi - 2 * K + j;
            if (r < 0) r = 0;
            if (r > IMAGE_HEIGHT - 1) r = IMAGE_HEIGHT - 1;
            sel[j*3 +: 3] = 3'(vi - r);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PREFILL;
            hor       <= '0;
            v         <= '0;
            srst      <= 1'b1;
            srst_cnt  <= 2'd2;
            wr_dly    <= '0;
            mv_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            row_sel_q <= '0;
        end else begin
            state_q <= state_d;
            srst    <= (srst_cnt != 2'd0);
            if (srst_cnt != 2'd0) srst_cnt <= srst_cnt - 2'd1;
            wr_dly  <= rd_en[NF-2:0];

            if (beat) begin
                if (hor == HOR_LAST) begin
                    hor <= '0;
                    if (state_q == FLUSH && v == V_FL_LAST) v <= '0;
                    else v <= v + 12'd1;
                end else begin
                    hor <= hor + 11'd1;
                end
            end

            mv_q      <= win_valid;
            sof_q     <= win_valid && (v == V_OUT_FIRST) && (hor == '0);
            eol_q     <= win_valid && (hor == HOR_LAST);
            eof_q     <= win_valid && (hor == HOR_LAST) && (v == V_OUT_LAST);
            row_sel_q <= win_valid ? sel : '0;
        end
    end

    assign bus.s_ready       = ready;
    assign bus.fifo_srst     = srst;
    assign bus.fifo_wr_en    = {wr_dly, accept};
    assign bus.fifo_rd_en    = rd_en;
    assign bus.row_sel       = row_sel_q;
    assign bus.m_pixel_valid = mv_q;
    assign bus.m_sof         = sof_q;
    assign bus.m_eol         = eol_q;
    assign bus.m_eof         = eof_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_line_window_scheduler.sv
// Scoreboard bench: 4x4/L=3 directed frames, reset and back-to-back cases,
// plus an 8x5/L=5 frame with random input gaps.
module tb_line_window_scheduler;
    localparam int WA = 4, HA = 4, LA = 3;
    localparam int WB = 8, HB = 5, LB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int n_checks = 0;
    int n_fail = 0;

    line_window_scheduler_if #(.LINES_NUM(LA)) bus_a ();
    line_window_scheduler_if #(.LINES_NUM(LB)) bus_b ();

    line_window_scheduler #(
        .IMAGE_WIDTH(WA), .IMAGE_HEIGHT(HA), .LINES_NUM(LA)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.slave)
    );

    line_window_scheduler #(
        .IMAGE_WIDTH(WB), .IMAGE_HEIGHT(HB), .LINES_NUM(LB)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.slave)
    );

    // Hand-derived tap selects per center row, entries are rows j=0..L-1.
    int sel_a [HA][LA] = '{'{1,1,0}, '{2,1,0}, '{2,1,0}, '{2,1,1}};
    int sel_b [HB][LB] = '{'{2,2,2,1,0}, '{3,3,2,1,0}, '{4,3,2,1,0},
                           '{4,3,2,1,1}, '{4,3,2,2,2}};

    logic [31:0] q_a [$];
    logic [31:0] q_b [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_code(input logic [14:0] sel,
        input logic sof, input logic eol, input logic eof);
        return {5'b0, eof, eol, sof, 9'b0, sel};
    endfunction

    function automatic logic [31:0] exp_a(input int c, input int x);
        logic [31:0] e = '0;
        for (int j = 0; j < LA; j++) e[j*3 +: 3] = 3'(sel_a[c][j]);
        e[24] = (c == 0 && x == 0);
        e[25] = (x == WA - 1);
        e[26] = (x == WA - 1 && c == HA - 1);
        return e;
    endfunction

    function automatic logic [31:0] exp_b(input int c, input int x);
        logic [31:0] e = '0;
        for (int j = 0; j < LB; j++) e[j*3 +: 3] = 3'(sel_b[c][j]);
        e[24] = (c == 0 && x == 0);
        e[25] = (x == WB - 1);
        e[26] = (x == WB - 1 && c == HB - 1);
        return e;
    endfunction

    task automatic push_a(input int n);
        for (int k = 0; k < n; k++) q_a.push_back(exp_a(k / WA, k % WA));
    endtask

    task automatic push_b(input int n);
        for (int k = 0; k < n; k++) q_b.push_back(exp_b(k / WB, k % WB));
    endtask

    // Output monitors
    always @(negedge clk) begin
        if (bus_a.m_pixel_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL A window: unexpected output at %0t", $time);
            end else begin
                check("A window",
                      act_code(15'(bus_a.row_sel), bus_a.m_sof,
                               bus_a.m_eol, bus_a.m_eof),
                      q_a.pop_front());
            end
        end
        if (bus_b.m_pixel_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL B window: unexpected output at %0t", $time);
            end else begin
                check("B window",
                      act_code(15'(bus_b.row_sel), bus_b.m_sof,
                               bus_b.m_eol, bus_b.m_eof),
                      q_b.pop_front());
            end
        end
    end

    // FIFO occupancy from the enables: no underflow, empty after drain
    int occ_a [LA-1];
    int occ_b [LB-1];
    logic [1:0] prev_a = 2'd0;
    logic [1:0] prev_b = 2'd0;

    always @(negedge clk) begin
        if (rst_a === 1'b1 || bus_a.fifo_srst === 1'b1) begin
            foreach (occ_a[i]) occ_a[i] = 0;
        end else begin
            if (prev_a == 2'd2 && bus_a.state == 2'd0)
                foreach (occ_a[i]) check("A fifo empty", occ_a[i], 0);
            foreach (occ_a[i]) begin
                if (bus_a.fifo_rd_en[i] === 1'b1)
                    check("A fifo underflow", 32'(occ_a[i] > 0), 1);
                occ_a[i] += int'(bus_a.fifo_wr_en[i]) - int'(bus_a.fifo_rd_en[i]);
            end
        end
        prev_a = bus_a.state;
        if (rst_b === 1'b1 || bus_b.fifo_srst === 1'b1) begin
            foreach (occ_b[i]) occ_b[i] = 0;
        end else begin
            if (prev_b == 2'd2 && bus_b.state == 2'd0)
                foreach (occ_b[i]) check("B fifo empty", occ_b[i], 0);
            foreach (occ_b[i]) begin
                if (bus_b.fifo_rd_en[i] === 1'b1)
                    check("B fifo underflow", 32'(occ_b[i] > 0), 1);
                occ_b[i] += int'(bus_b.fifo_wr_en[i]) - int'(bus_b.fifo_rd_en[i]);
            end
        end
        prev_b = bus_b.state;
    end

    task automatic feed_a(input int npix);
        int n = 0;
        int cyc = 0;
        while (n < npix && cyc < 200) begin
            @(posedge clk); #1;
            bus_a.s_pixel_valid = 1'b1;
            @(negedge clk);
            if (bus_a.s_ready) n++;
            cyc++;
        end
        @(posedge clk); #1;
        bus_a.s_pixel_valid = 1'b0;
        check("A pixels accepted", n, npix);
    endtask

    task automatic wait_drain_a(input string name, input int exp_len);
        int fl = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_a.state == 2'd2) fl++;
            else if (fl > 0) break;
        end
        check(name, fl, exp_len);
        check("A idle state", 32'(bus_a.state), 0);
    endtask

    task automatic run_a();
        int n = 0;
        int cyc = 0;
        int stall = 0;
        logic [1:0] rd_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b11};

        rst_a = 1'b1;
        bus_a.s_pixel_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("A reset state", 32'(bus_a.state), 0);
        check("A reset s_ready", 32'(bus_a.s_ready), 0);
        check("A reset fifo_srst", 32'(bus_a.fifo_srst), 1);
        check("A reset m_pixel_valid", 32'(bus_a.m_pixel_valid), 0);
        check("A reset rd_en", 32'(bus_a.fifo_rd_en), 0);
        check("A reset wr_en", 32'(bus_a.fifo_wr_en), 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int k = 0; k < 10 && !bus_a.s_ready; k++) @(negedge clk);
        check("A ready after reset", 32'(bus_a.s_ready), 1);

        // Two frames back to back; the second waits out the drain
        push_a(WA * HA);
        while (n < 2 * WA * HA && cyc < 200) begin
            @(posedge clk); #1;
            bus_a.s_pixel_valid = 1'b1;
            @(negedge clk);
            if (bus_a.s_ready) begin
                if (n < WA * HA) begin
                    check("A rd_en", 32'(bus_a.fifo_rd_en), 32'(rd_tab[n / WA]));
                    check("A wr_en", 32'(bus_a.fifo_wr_en), (n >= WA + 1) ? 3 : 1);
                end
                if (n == WA * HA) begin
                    check("A drain hold-off cycles", stall, (LA - 1) * WA);
                    push_a(WA * HA);
                end
                n++;
            end else if (n == WA * HA) begin
                check("A drain state", 32'(bus_a.state), 2);
                check("A drain rd_en", 32'(bus_a.fifo_rd_en), (stall < WA) ? 3 : 2);
                check("A drain wr_en", 32'(bus_a.fifo_wr_en), (stall <= WA) ? 2 : 0);
                stall++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        bus_a.s_pixel_valid = 1'b0;
        check("A back-to-back accepted", n, 2 * WA * HA);
        wait_drain_a("A drain length", (LA - 1) * WA);

        // Abort at v=2, hor=1: only rows c=0 and c=1 col 0 came out
        push_a(WA + 1);
        feed_a(2 * WA);
        @(posedge clk); #1;
        bus_a.s_pixel_valid = 1'b1;
        @(negedge clk);
        check("A mid-frame state", 32'(bus_a.state), 1);
        @(posedge clk); #1;
        bus_a.s_pixel_valid = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        check("A s_ready in reset", 32'(bus_a.s_ready), 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("A srst hold", 32'(bus_a.fifo_srst), (k < 3) ? 1 : 0);
            check("A ready hold", 32'(bus_a.s_ready), (k < 3) ? 0 : 1);
            if (k == 0) begin
                check("A abort state", 32'(bus_a.state), 0);
                check("A abort outputs",
                      act_code(15'(bus_a.row_sel), bus_a.m_sof,
                               bus_a.m_eol, bus_a.m_eof), 0);
                check("A abort valid", 32'(bus_a.m_pixel_valid), 0);
                check("A abort enables",
                      {28'b0, bus_a.fifo_wr_en, bus_a.fifo_rd_en}, 0);
            end
        end
        check("A abort queue", q_a.size(), 0);

        push_a(WA * HA);
        feed_a(WA * HA);
        wait_drain_a("A clean drain length", (LA - 1) * WA);
        repeat (2) @(negedge clk);
        check("A queue drained", q_a.size(), 0);
    endtask

    task automatic run_b();
        int n = 0;
        int cyc = 0;
        int fl = 0;
        logic vld;

        rst_b = 1'b1;
        bus_b.s_pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("B reset state", 32'(bus_b.state), 0);
        check("B reset s_ready", 32'(bus_b.s_ready), 0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int k = 0; k < 10 && !bus_b.s_ready; k++) @(negedge clk);
        check("B ready after reset", 32'(bus_b.s_ready), 1);

        push_b(WB * HB);
        while (n < WB * HB && cyc < 2000) begin
            @(posedge clk); #1;
            vld = ($urandom_range(0, 99) < 30);
            bus_b.s_pixel_valid = vld;
            @(negedge clk);
            if (vld && bus_b.s_ready) begin
                n++;
            end else if (!vld && bus_b.state != 2'd2) begin
                check("B gap rd_en", 32'(bus_b.fifo_rd_en), 0);
                check("B gap wr_en0", 32'(bus_b.fifo_wr_en[0]), 0);
            end
            cyc++;
        end
        @(posedge clk); #1;
        bus_b.s_pixel_valid = 1'b0;
        check("B pixels accepted", n, WB * HB);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_b.state == 2'd2) fl++;
            else if (fl > 0) break;
        end
        check("B drain length", fl, (LB - 1) * WB);
        repeat (2) @(negedge clk);
        check("B queue drained", q_b.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.s_pixel_valid = 1'b0;
        bus_b.s_pixel_valid = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
